// File: rtl/exe_stage_mc.sv
// exe_stage_mc: multi-cycle execute stage.
// Picks operands from the register file or from forwarding buses. Single-cycle
// ALU ops finish in 1 cycle. MUL (and DIVU when EXE_STAGE_DIV_EN is defined)
// runs one shift step per cycle, so its latency is WIDTH+1.
// Backpressure: in_ready drops while iterating, while a held result is not
// accepted, or during flush. Results stay stable while out_valid && !out_ready.
// Ports:
//   clk, rst (async active-low), flush
//   in_valid/in_ready, exe_cmd, val1, val2, st_value_in, sll_amount,
//   val1_sel/val2_sel/st_val_sel, fwd_data (slice k = [k*WIDTH +: WIDTH])
//   out_valid/out_ready, alu_result, st_value_out, busy
// Optional feature macro: EXE_STAGE_DIV_EN (cmd 11 = iterative unsigned divide).
module exe_stage_mc #(
  parameter int WIDTH    = 32,
  parameter int FWD_SRCS = 2,
  parameter int SEL_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                exe_cmd,
  input  logic [WIDTH-1:0]          val1,
  input  logic [WIDTH-1:0]          val2,
  input  logic [WIDTH-1:0]          st_value_in,
  input  logic [7:0]                sll_amount,
  input  logic [SEL_LEN-1:0]        val1_sel,
  input  logic [SEL_LEN-1:0]        val2_sel,
  input  logic [SEL_LEN-1:0]        st_val_sel,
  input  logic [FWD_SRCS*WIDTH-1:0] fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          alu_result,
  output logic [WIDTH-1:0]          st_value_out,
  output logic                      busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
`ifdef EXE_STAGE_DIV_EN
    S_DIV_IT = 2'd2,
`endif
    S_MUL_IT = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_result;
  logic [WIDTH-1:0] r_st_value;
  logic [WIDTH-1:0] r_st_hold;
  // Iteration registers, shared by MUL and DIVU:
  //   MUL : r_x = partial product, r_y = shifted multiplicand, r_z = remaining multiplier
  //   DIVU: r_x = partial remainder, r_y = divisor, r_z = dividend shifting into quotient
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_st;
  logic [WIDTH-1:0] w_alu;
  logic             w_issue;
  logic             w_is_mul;
  logic             w_last;
  logic             w_amt_big;
  logic [WIDTH-1:0] w_acc_nxt;

  // sel 0 and sel > FWD_SRCS both fall back to the stage's own operand.
  function automatic logic [WIDTH-1:0] f_pick(
    input logic [WIDTH-1:0]          own,
    input logic [SEL_LEN-1:0]        sel,
    input logic [FWD_SRCS*WIDTH-1:0] bus
  );
    f_pick = own;
    for (int k = 1; k <= FWD_SRCS; k++) begin
      if (int'(sel) == k) f_pick = bus[(k-1)*WIDTH +: WIDTH];
    end
  endfunction

  assign w_a  = f_pick(val1, val1_sel, fwd_data);
  assign w_b  = f_pick(val2, val2_sel, fwd_data);
  assign w_st = f_pick(st_value_in, st_val_sel, fwd_data);

  assign in_ready     = (r_state == S_IDLE) && (!r_out_valid || out_ready) && !flush;
  assign w_issue      = in_valid && in_ready;
  assign w_is_mul     = (exe_cmd == 4'd10);
  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  assign w_amt_big    = (32'(sll_amount) >= WIDTH);
  assign w_acc_nxt    = r_z[0] ? (r_x + r_y) : r_x;

  assign out_valid    = r_out_valid;
  assign alu_result   = r_alu_result;
  assign st_value_out = r_st_value;
  assign busy         = (r_state != S_IDLE);

`ifdef EXE_STAGE_DIV_EN
  logic             w_is_div;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quot_nxt;

  assign w_is_div    = (exe_cmd == 4'd11);
  // Restoring step. A zero divisor makes every trial succeed, which yields
  // the all-ones quotient without a special case.
  assign w_div_shift = {r_x, r_z[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_y};
  assign w_div_ge    = !w_div_trial[WIDTH];
  assign w_rem_nxt   = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
  assign w_quot_nxt  = {r_z[WIDTH-2:0], w_div_ge};
`endif

  // Single-cycle ALU. MUL, DIVU and 12-15 return 0 here; MUL/DIVU results come
  // from the iteration registers.
  always_comb begin
    w_alu = '0;
    case (exe_cmd)
      4'd0: w_alu = w_a + w_b;
      4'd1: w_alu = w_a - w_b;
      4'd2: w_alu = w_a & w_b;
      4'd3: w_alu = w_a | w_b;
      4'd4: w_alu = ~(w_a | w_b);
      4'd5: w_alu = w_a ^ w_b;
      4'd6: w_alu = w_amt_big ? '0 : (w_a << sll_amount);
      4'd7: w_alu = w_amt_big ? '0 : (w_a >> sll_amount);
      4'd8: w_alu = w_amt_big ? {WIDTH{w_a[WIDTH-1]}} : WIDTH'($signed(w_a) >>> sll_amount);
      4'd9: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue && w_is_mul) w_state_nxt = S_MUL_IT;
`ifdef EXE_STAGE_DIV_EN
          else if (w_issue && w_is_div) w_state_nxt = S_DIV_IT;
`endif
        end
        S_MUL_IT: if (w_last) w_state_nxt = S_IDLE;
`ifdef EXE_STAGE_DIV_EN
        S_DIV_IT: if (w_last) w_state_nxt = S_IDLE;
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_alu_result <= '0;
      r_st_value   <= '0;
      r_st_hold    <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
    end else if (flush) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_cnt     <= '0;
            r_st_hold <= w_st;
            if (w_is_mul) begin
              // Old result was consumed this edge; nothing valid until done.
              r_out_valid <= 1'b0;
              r_x         <= '0;
              r_y         <= w_a;
              r_z         <= w_b;
            end
`ifdef EXE_STAGE_DIV_EN
            else if (w_is_div) begin
              r_out_valid <= 1'b0;
              r_x         <= '0;
              r_y         <= w_b;
              r_z         <= w_a;
            end
`endif
            else begin
              r_out_valid  <= 1'b1;
              r_alu_result <= w_alu;
              r_st_value   <= w_st;
            end
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL_IT: begin
          r_x   <= w_acc_nxt;
          r_y   <= r_y << 1;
          r_z   <= r_z >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt        <= '0;
            r_out_valid  <= 1'b1;
            r_alu_result <= w_acc_nxt;
            r_st_value   <= r_st_hold;
          end
        end
`ifdef EXE_STAGE_DIV_EN
        S_DIV_IT: begin
          r_x   <= w_rem_nxt;
          r_z   <= w_quot_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt        <= '0;
            r_out_valid  <= 1'b1;
            r_alu_result <= w_quot_nxt;
            r_st_value   <= r_st_hold;
          end
        end
`endif
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;
  localparam int W  = 32;
  localparam int NF = 2;
  localparam int SL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    exe_cmd = '0;
  logic [W-1:0]  val1 = '0, val2 = '0, st_value_in = '0;
  logic [7:0]    sll_amount = '0;
  logic [SL-1:0] val1_sel = '0, val2_sel = '0, st_val_sel = '0;
  logic [NF*W-1:0] fwd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  alu_result, st_value_out;
  logic          busy;

  exe_stage_mc #(.WIDTH(W), .FWD_SRCS(NF), .SEL_LEN(SL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .st_value_in(st_value_in),
    .sll_amount(sll_amount), .val1_sel(val1_sel), .val2_sel(val2_sel),
    .st_val_sel(st_val_sel), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_result(alu_result), .st_value_out(st_value_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] pick(input logic [W-1:0] own, input logic [SL-1:0] sel,
                                        input logic [NF*W-1:0] bus);
    int s;
    s = int'(sel);
    if (s >= 1 && s <= NF) return bus[(s-1)*W +: W];
    return own;
  endfunction

  function automatic logic [W-1:0] model_alu(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [7:0] amt);
    logic [63:0] p;
    int n;
    n = int'(amt);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return ~(a | b);
      4'd5: return a ^ b;
      4'd6: return (n >= W) ? '0 : a << n;
      4'd7: return (n >= W) ? '0 : a >> n;
      4'd8: return (n >= W) ? (a[W-1] ? '1 : '0) : W'($signed(a) >>> n);
      4'd9: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd10: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
`ifdef EXE_STAGE_DIV_EN
      4'd11: return (b == 0) ? '1 : a / b;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic bit is_iter(input logic [3:0] c);
`ifdef EXE_STAGE_DIV_EN
    return (c == 4'd10) || (c == 4'd11);
`else
    return (c == 4'd10);
`endif
  endfunction

  logic         m_vld = 1'b0;
  logic [W-1:0] m_res = '0, m_st = '0, m_pres = '0, m_pst = '0;
  int           m_cnt = 0;   // edges left until an iterative result lands

  always @(posedge clk or negedge rst) begin
    logic [W-1:0] r, s;
    if (!rst) begin
      m_vld = 1'b0; m_res = '0; m_st = '0; m_cnt = 0;
    end else if (flush) begin
      m_vld = 1'b0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin m_vld = 1'b1; m_res = m_pres; m_st = m_pst; end
    end else if (in_valid && (!m_vld || out_ready)) begin
      r = model_alu(exe_cmd, pick(val1, val1_sel, fwd_data), pick(val2, val2_sel, fwd_data),
                    sll_amount);
      s = pick(st_value_in, st_val_sel, fwd_data);
      if (is_iter(exe_cmd)) begin
        m_cnt = W; m_vld = 1'b0; m_pres = r; m_pst = s;
      end else begin
        m_vld = 1'b1; m_res = r; m_st = s;
      end
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", W'(in_ready), W'(m_cnt == 0 && (!m_vld || out_ready) && !flush));
      chk("out_valid", W'(out_valid), W'(m_vld));
      chk("busy", W'(busy), W'(m_cnt > 0));
      if (m_vld) begin
        chk("alu_result", alu_result, m_res);
        chk("st_value_out", st_value_out, m_st);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; returns just after the
  // accepting edge (at negedge+1), where a single-cycle result is visible.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] s, input logic [7:0] amt,
                       input logic [SL-1:0] sa, input logic [SL-1:0] sb, input logic [SL-1:0] ss);
    bit done;
    done = 1'b0;
    exe_cmd = c; val1 = a; val2 = b; st_value_in = s; sll_amount = amt;
    val1_sel = sa; val2_sel = sb; st_val_sel = ss; in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      #1;
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("issue_accepted", W'(done), W'(1));
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    fwd_data = {32'h0000_0099, 32'h0000_0007};
    repeat (3) tick();
    chk("reset_alu", alu_result, '0);
    chk("reset_st", st_value_out, '0);
    chk("reset_vld", W'(out_valid), '0);
    chk("reset_busy", W'(busy), '0);
    rst = 1'b1;
    tick();

    // Forwarding: val2 from slice0 (7), store from slice1 (0x99); result held.
    issue(4'd0, 32'd5, 32'd100, 32'h55, 8'd0, 2'd0, 2'd1, 2'd2);
    chk("add_fwd", alu_result, 32'd12);
    chk("add_fwd_vld", W'(out_valid), W'(1));
    chk("add_fwd_st", st_value_out, 32'h99);
    out_ready = 1'b1;
    // sel 3 is beyond FWD_SRCS -> own operands.
    issue(4'd0, 32'd5, 32'd100, 32'h55, 8'd0, 2'd0, 2'd3, 2'd3);
    chk("add_sel3", alu_result, 32'd105);
    chk("add_sel3_st", st_value_out, 32'h55);

    issue(4'd8, 32'h8000_0000, 32'd0, 32'd0, 8'd40, 2'd0, 2'd0, 2'd0);
    chk("sra_big", alu_result, 32'hFFFF_FFFF);
    issue(4'd7, 32'h8000_0000, 32'd0, 32'd0, 8'd40, 2'd0, 2'd0, 2'd0);
    chk("srl_big", alu_result, 32'd0);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("slt_neg", alu_result, 32'd1);
    issue(4'd1, 32'd3, 32'd5, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("sub_wrap", alu_result, 32'hFFFF_FFFE);
    issue(4'd4, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("nor", alu_result, 32'h0000_000F);
    issue(4'd5, 32'h0000_FF00, 32'h0000_0FF0, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("xor", alu_result, 32'h0000_F0F0);
    issue(4'd6, 32'd1, 32'd0, 32'd0, 8'd4, 2'd0, 2'd0, 2'd0);
    chk("sll", alu_result, 32'd16);

    // MUL with val1 forwarded; the bus changes mid-iteration and must be ignored.
    fwd_data[31:0] = 32'h0001_0003;
    issue(4'd10, 32'hDEAD_BEEF, 32'h0002_0005, 32'h1234, 8'd0, 2'd1, 2'd0, 2'd0);
    fwd_data = {32'hAAAA_5555, 32'h1357_9BDF};
    wait_out(cyc);
    chk("mul_latency", W'(cyc), 32'd33);
    chk("mul_result", alu_result, 32'h000B_000F);
    chk("mul_st", st_value_out, 32'h1234);

    // Back-to-back ADDs, one per cycle.
    for (int i = 0; i < 4; i++) begin
      exe_cmd = 4'd0; val1 = 32'(i * 10); val2 = 32'd1;
      val1_sel = '0; val2_sel = '0; st_val_sel = '0; in_valid = 1'b1;
      tick();
      chk("b2b_add", alu_result, 32'(i * 10 + 1));
    end
    in_valid = 1'b0;
    tick();

    // Downstream stall: result held, issue blocked, then swap on the same edge.
    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    exe_cmd = 4'd0; val1 = 32'd8; val2 = 32'd8; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_res", alu_result, 32'd7);
      chk("hold_rdy", W'(in_ready), '0);
    end
    out_ready = 1'b1;
    tick();
    chk("swap_res", alu_result, 32'd16);
    in_valid = 1'b0;
    tick();

    // Flush during MUL; an ADD offered in the flush cycle must not issue.
    issue(4'd10, 32'd3, 32'd5, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    repeat (9) tick();
    exe_cmd = 4'd0; val1 = 32'd1; val2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_busy", W'(busy), '0);
    chk("flush_vld", W'(out_valid), '0);
    chk("flush_rdy", W'(in_ready), W'(1));
    tick();

    // Async reset mid-MUL.
    issue(4'd10, 32'd7, 32'd9, 32'd3, 8'd0, 2'd0, 2'd0, 2'd0);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk("rst_alu", alu_result, '0);
    chk("rst_st", st_value_out, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_vld", W'(out_valid), '0);
    tick();
    rst = 1'b1;
    tick();

    issue(4'd0, 32'd2, 32'd3, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("add_pre11", alu_result, 32'd5);
`ifdef EXE_STAGE_DIV_EN
    issue(4'd11, 32'd100, 32'd7, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    wait_out(cyc);
    chk("div_latency", W'(cyc), 32'd33);
    chk("div_result", alu_result, 32'd14);
    issue(4'd11, 32'd5, 32'd0, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    wait_out(cyc);
    chk("div0_latency", W'(cyc), 32'd33);
    chk("div0_result", alu_result, 32'hFFFF_FFFF);
`else
    issue(4'd11, 32'd100, 32'd7, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("cmd11_result", alu_result, 32'd0);
    chk("cmd11_vld", W'(out_valid), W'(1));
`endif
    issue(4'd0, 32'd2, 32'd3, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    issue(4'd13, 32'd9, 32'd9, 32'd0, 8'd0, 2'd0, 2'd0, 2'd0);
    chk("cmd13_result", alu_result, 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage_mc.md
Name: exe_stage_mc

Overview:
- Parametrised multi-cycle execute stage; next generation of the single-cycle EXE stage.
- Selects each operand (val1, val2, store value) from its own value or from one of FWD_SRCS forwarding buses.
- Single-cycle ALU ops complete in one cycle; MUL (and optionally DIVU) runs iteratively.
- Valid/ready handshake on both sides, plus a flush input.
- Sits between the ID/EXE and EXE/MEM pipeline registers; in_ready deasserting is the hazard unit's stall source.

Parameters:
- WIDTH, 32, datapath width in bits.
- FWD_SRCS, 2, number of forwarding buses (index 0 = MEM, 1 = WB, further = deeper stages).
- SEL_LEN, 2, width of each forwarding select; must satisfy 2^SEL_LEN > FWD_SRCS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of in-flight and held work.
- in_valid  in  1  issue request.
- in_ready  out  1  stage accepts issue this cycle.
- exe_cmd  in  4  operation code.
- val1, val2  in  WIDTH  register-file operands.
- st_value_in  in  WIDTH  store data.
- sll_amount  in  8  shift amount.
- val1_sel, val2_sel, st_val_sel  in  SEL_LEN  forwarding selects.
- fwd_data  in  FWD_SRCS*WIDTH  forwarding buses; slice k = bits [k*WIDTH +: WIDTH].
- out_valid  out  1  result held.
- out_ready  in  1  downstream accepts.
- alu_result  out  WIDTH  registered result.
- st_value_out  out  WIDTH  registered forwarded store data.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset: state IDLE; out_valid=0, alu_result=0, st_value_out=0, busy=0, iteration counter=0.
- Forward select (combinational, sampled at issue):
  - sel=0 selects own input.
  - sel=k with 1<=k<=FWD_SRCS selects fwd_data slice k-1.
  - sel>FWD_SRCS selects own input.
- Issue fires when in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Commands (arithmetic mod 2^WIDTH):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR.
  - 6 SLL: val1<<amt. 7 SRL. 8 SRA.
  - Shifts take amt = sll_amount. If amt>=WIDTH: SLL/SRL give 0; SRA gives all sign bits.
  - 9 SLT: signed, result 1 or 0.
  - 10 MUL: low WIDTH bits of the unsigned product.
  - 11 DIVU: see Optional Feature.
  - 12-15: result 0, single-cycle.
- States:
  - IDLE: on issue of a single-cycle cmd, load result and store value; out_valid=1 next edge (latency 1). On MUL, go to MUL_IT with counter=0 and busy=1.
  - MUL_IT: one shift-add step per cycle. After WIDTH steps, load result, set out_valid, go to IDLE. Total latency WIDTH+1 cycles from issue.
  - DIV_IT: present only when the Optional Feature is compiled in.
- Output hold: while out_valid && !out_ready, alu_result and st_value_out stay stable. out_valid clears on a handshake unless a new issue fires the same edge; back-to-back single-cycle ops sustain 1 op/cycle.
- Flush: next edge forces IDLE, out_valid=0, busy=0, counter=0; the issue in the same cycle is blocked.
- Operands are captured at issue; forwarding-bus changes during iteration are ignored.
- Async reset mid-iteration aborts immediately to reset values.

Optional Feature:
- Macro: EXE_STAGE_DIV_EN.
- Defined: cmd 11 = DIVU, WIDTH-step restoring division (state DIV_IT), latency WIDTH+1, result = quotient.
  - Divide by zero returns all ones in the same latency.
  - st_value_out behaves as for other ops.
- Undefined: cmd 11 behaves like 12-15 (single-cycle, result 0) and no DIV_IT logic exists.

Test Plan:
- ADD, val1=5, val2 forwarded sel=1 with fwd slice0=7 -> alu_result=12, out_valid one cycle after issue; then sel=3 (>FWD_SRCS) -> val2 used.
- SRA val1=0x80000000, amt=40 -> 0xFFFFFFFF; SRL same inputs -> 0; SLT -1 vs 1 -> 1.
- MUL 0x0001_0003 x 0x0002_0005 -> 0x000B_000F after exactly 33 cycles; busy=1 and in_ready=0 throughout.
- Back-to-back ADDs with out_ready=1 -> one result per cycle. Drop out_ready for 3 cycles -> outputs stable, in_ready=0.
- Flush at MUL cycle 10 -> next cycle IDLE, busy=0, out_valid=0. Reset pulse mid-MUL -> all outputs 0.
- EXE_STAGE_DIV_EN: 100/7 -> 14 after 33 cycles; 5/0 -> 0xFFFFFFFF. Without the macro, cmd 11 -> 0 after 1 cycle.
